// File: rtl/trimmer_pkg.sv
// Shared definitions for the multi-channel data trimmer: blank pattern,
// live-sample classification and frame-length field sizing.
package trimmer_pkg;

    // Widest channel sample the helper functions can classify.
    localparam int MAX_DATA_WIDTH = 1024;

    // All-ones blank pattern occupying the low `width` bits.
    function automatic logic [MAX_DATA_WIDTH-1:0] blank(input int width);
        logic [MAX_DATA_WIDTH-1:0] pattern;
        pattern = '0;
        for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
            if (i < width) begin
                pattern[i] = 1'b1;
            end
        end
        return pattern;
    endfunction

    // A sample is live when qualified and not the blank pattern. Callers
    // pad unused upper bits with ones so only the real sample bits decide.
    function automatic logic is_live(input logic [MAX_DATA_WIDTH-1:0] data,
                                     input logic                      valid);
        return valid & ~(&data);
    endfunction

    // Width needed to hold a frame length of 0..max_len.
    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/trimmer_lane.sv
// One trimmer channel: fixed-latency delay line, live tracking, run counter
// and the frame start/end/trunc/length flags aligned with the delayed data.
module trimmer_lane
    import trimmer_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int LATENCY    = 2,
    parameter  int MAX_LEN    = 256,
    localparam int CNT_WIDTH  = cnt_width(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  trimmer_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_trunc,
    output logic [CNT_WIDTH-1:0]  frame_len
);

    localparam logic [DATA_WIDTH-1:0] BLANK_WORD = DATA_WIDTH'(blank(DATA_WIDTH));
    localparam logic [CNT_WIDTH-1:0]  LEN_LIMIT  = CNT_WIDTH'(MAX_LEN);

    logic [MAX_DATA_WIDTH-1:0] din_ext;
    logic                      live_in;

    // Stage i holds the sample that entered i cycles ago; stage 0 is the
    // unregistered input and is not stored.
    logic [DATA_WIDTH-1:0] data_pipe [1:LATENCY];
    logic [LATENCY:1]      live_pipe;
    logic [LATENCY-1:0]    live_vec;

    logic                 cur_live;
    logic                 look_live;
    logic [CNT_WIDTH-1:0] run_cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 forced_end;
    logic                 natural_end;
    logic                 end_next;
    logic                 start_next;
    logic                 trunc_next;

    // Pad the sample with ones above DATA_WIDTH so the shared classifier sees
    // only the real bits when testing for the blank pattern.
    always_comb begin
        // NOTE: give every combinationally assigned signal a full default
        // before any partial or conditional write, otherwise a latch appears.
        din_ext                   = '1;
        din_ext[DATA_WIDTH-1:0]   = din;
    end

    assign live_in   = is_live(din_ext, din_valid);
    assign live_vec  = {live_pipe[LATENCY-1:1], live_in};
    assign cur_live  = live_vec[LATENCY-1];
    assign look_live = live_vec[LATENCY-2];

    assign dout          = data_pipe[LATENCY];
    assign trimmer_valid = live_pipe[LATENCY];

    // Decide the flags for the sample about to enter the output stage.
    always_comb begin
        cnt_inc     = run_cnt + CNT_WIDTH'(1);
        forced_end  = cur_live & (cnt_inc == LEN_LIMIT);
        natural_end = cur_live & ~look_live;
        end_next    = forced_end | natural_end;
        // A forced end that is also a natural end has no follow-on sample.
        trunc_next  = forced_end & look_live;
        start_next  = cur_live & (~trimmer_valid | frame_end);
    end

    // Shift data and live bits one stage per cycle, regardless of validity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data stages are reset (not left uninitialised) because
            // the output must read as the blank pattern straight out of reset.
            for (int i = 1; i <= LATENCY; i++) begin
                data_pipe[i] <= BLANK_WORD;
            end
            live_pipe <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every
            // stage samples its predecessor's value from before the edge.
            data_pipe[1] <= din;
            live_pipe[1] <= live_in;
            for (int i = 2; i <= LATENCY; i++) begin
                data_pipe[i] <= data_pipe[i-1];
                live_pipe[i] <= live_pipe[i-1];
            end
        end
    end

    // Register frame flags and length alongside the output sample; keep the
    // run counter for the frame currently being emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt     <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_trunc <= 1'b0;
            frame_len   <= '0;
        end else begin
            frame_start <= start_next;
            frame_end   <= end_next;
            frame_trunc <= trunc_next;
            frame_len   <= end_next ? cnt_inc : '0;
            run_cnt     <= (end_next || !cur_live) ? '0 : cnt_inc;
        end
    end

endmodule

// File: rtl/multi_ch_data_trimmer.sv
// Multi-channel data trimmer top: unpacks the channel buses, instantiates one
// independent trimmer lane per channel and repacks the results.
module multi_ch_data_trimmer
    import trimmer_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int N_CH       = 4,
    parameter  int LATENCY    = 2,
    parameter  int MAX_LEN    = 256,
    localparam int CNT_WIDTH  = cnt_width(MAX_LEN)
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [N_CH*DATA_WIDTH-1:0] DIN,
    input  logic [N_CH-1:0]            DIN_VALID,
    output logic [N_CH*DATA_WIDTH-1:0] DOUT,
    output logic [N_CH-1:0]            TRIMMER_VALID,
    output logic [N_CH-1:0]            FRAME_START,
    output logic [N_CH-1:0]            FRAME_END,
    output logic [N_CH-1:0]            FRAME_TRUNC,
    output logic [N_CH*CNT_WIDTH-1:0]  FRAME_LEN
);

    if (LATENCY < 2 || LATENCY > 16) begin : g_latency_check
        $error("multi_ch_data_trimmer: LATENCY must be in 2..16");
    end
    if (MAX_LEN < 1) begin : g_max_len_check
        $error("multi_ch_data_trimmer: MAX_LEN must be 1 or more");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_width_check
        $error("multi_ch_data_trimmer: DATA_WIDTH out of supported range");
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        trimmer_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .LATENCY    (LATENCY),
            .MAX_LEN    (MAX_LEN)
        ) u_lane (
            .clk           (CLK),
            .rst           (RESET),
            .din           (DIN[c*DATA_WIDTH +: DATA_WIDTH]),
            .din_valid     (DIN_VALID[c]),
            .dout          (DOUT[c*DATA_WIDTH +: DATA_WIDTH]),
            .trimmer_valid (TRIMMER_VALID[c]),
            .frame_start   (FRAME_START[c]),
            .frame_end     (FRAME_END[c]),
            .frame_trunc   (FRAME_TRUNC[c]),
            .frame_len     (FRAME_LEN[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: doc/multi_ch_data_trimmer.md
# multi_ch_data_trimmer

Parametrised, multi-channel successor to the single-lane data trimmer. Each channel delays its samples through a fixed-latency pipeline and qualifies every sample as live (valid and not the all-ones blank pattern). It groups contiguous live samples into frames, flagging frame start and end and reporting frame length. Frames longer than MAX_LEN are split. The block sits between the ADC sample formatter and the trigger/packetiser logic.

## Interface
- DATA_WIDTH, 64, bits per channel sample
- N_CH, 4, number of independent channels
- LATENCY, 2, input-to-output pipeline depth in cycles; legal range is 2 to 16
- MAX_LEN, 256, maximum live samples per frame before a forced split; must be 1 or more
- CNT_WIDTH (localparam), $clog2(MAX_LEN+1), width of each frame-length field
- CLK  in  1  single clock; all logic is on the rising edge
- RESET  in  1  asynchronous, active-high reset
- DIN  in  N_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- DIN_VALID  in  N_CH  per-channel input qualifier
- DOUT  out  N_CH*DATA_WIDTH  delayed samples, same packing as DIN
- TRIMMER_VALID  out  N_CH  output sample is live
- FRAME_START  out  N_CH  output sample is the first sample of a frame
- FRAME_END  out  N_CH  output sample is the last sample of a frame
- FRAME_TRUNC  out  N_CH  the end flagged on this sample was forced by MAX_LEN
- FRAME_LEN  out  N_CH*CNT_WIDTH  sample count of the frame; meaningful only while FRAME_END=1

## Operation
- Channels are fully independent and there is no cross-channel interaction.
- Live classification: live = DIN_VALID[c] & ~&DIN[c]. The blank pattern is all ones.
- Data propagates every cycle regardless of validity.
- Pipeline stages are numbered 0 to LATENCY. Stage 0 is the unregistered input and stage LATENCY is the output.
- Data and live bits shift one stage per cycle.
- End decision: made when a sample moves from stage LATENCY-1 to stage LATENCY.
  - Lookahead is the live bit at stage LATENCY-2 (when LATENCY=2 this is the combinational input).
  - Natural end: the current sample is live and the lookahead is not live.
  - Forced end: the current sample is live and run_cnt+1 == MAX_LEN.
- Per-channel counter run_cnt (CNT_WIDTH bits):
  - Increments on each live sample entering the output stage.
  - Clears to 0 on any end.
  - Holds at 0 on non-live samples.
- FRAME_START = live & (previous output sample was not live, or the previous output sample had FRAME_END).
- FRAME_LEN = run_cnt + 1 on the end sample, otherwise 0.
- FRAME_TRUNC = forced end & lookahead live, so the next sample starts a new frame immediately.
  - A forced end that coincides with a natural end is not truncated; FRAME_TRUNC = 0.
- FRAME_START, FRAME_END, FRAME_TRUNC and FRAME_LEN are 0 whenever TRIMMER_VALID is 0.
- The MAX_LEN=1 boundary: every live sample is its own frame with FRAME_START=FRAME_END=1 and FRAME_LEN=1.

## Timing
- Latency: DIN at edge n appears on DOUT after edge n+LATENCY. All flags are aligned with DOUT.
- Throughput: one sample per channel per cycle. There is no back-pressure.
- Reset values (asynchronous, immediate):
  - DOUT and all internal data stages are all ones.
  - TRIMMER_VALID, FRAME_* and FRAME_LEN are 0.
  - run_cnt is 0 and all live bits are 0.
- Reset mid-frame: the frame is discarded with no FRAME_END emitted. The first live sample after release produces FRAME_START.
- Samples in flight at the time of reset are lost. Output is blank and non-live for LATENCY cycles after release.
- A single isolated live sample produces FRAME_START=FRAME_END=1 and FRAME_LEN=1 in the same cycle.

## Structure
- Shared package trimmer_pkg holds:
  - the blank-pattern function blank(width), which returns all ones;
  - the is_live(data, valid) function;
  - the cnt_width(max_len) function.
- Sub-module trimmer_lane implements one channel: the delay line, live tracking, run counter and flags.
- The top level uses a generate loop to instantiate N_CH lanes and handles only bus packing and unpacking.
- Elaboration-time assertions enforce LATENCY >= 2 and MAX_LEN >= 1.

## Test plan
- Reset: assert RESET with DIN at random values, check DOUT all ones and all flags 0. Release RESET and hold the input blank; outputs stay blank.
- Single frame, ch0, LATENCY=2: drive 5 live samples 0x1..0x5 then a blank. DOUT shows 0x1..0x5 two cycles later, with FRAME_START on 0x1, FRAME_END on 0x5 and FRAME_LEN=5.
- Forced split with MAX_LEN=4: drive 10 contiguous live samples.
  - Frames have lengths 4, 4 and 2.
  - FRAME_TRUNC=1 on the ends of the first two frames and 0 on the last.
  - FRAME_START appears on samples 1, 5 and 9.
- Gaps and isolation: the pattern live, DIN_VALID=0, live, all-ones with valid=1, live gives three 1-sample frames, each with START=END=1.
- Channel independence with N_CH=4, LATENCY=5: drive different frame patterns on each channel. Each lane matches a reference model and output timing is exactly 5 cycles.
- Mid-frame reset: assert RESET on the 3rd sample of a 6-sample frame. Check no FRAME_END is emitted and the next post-reset frame reports FRAME_LEN counted from 1.
